imem_loader: RTL and testbench

Instruction-memory responder for the pipelined RISC-V core: the far end of the core's `PC_to_INSTMEM` → `instruction` fetch interface. After reset it accepts a program as a byte stream over a valid/ready port and packs it little-endian into 32-bit words, holding the core in reset while it does so. It then serves instruction fetches from the loaded image. This replaces the hard-coded instruction ROM, so benches and boards can load programs at run time.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 40 ++++
 rtl/imem_loader.sv | 84 ++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared RISC-V definitions: the canonical NOP word, the loader state encoding
// and the word-count width helper.
package imem_loader_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // word_count must be able to hold DEPTH itself, not just DEPTH-1
  function automatic int wc_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles accepted load bytes into little-endian 32-bit words and flags
// when a word is complete (lane 3 filled, or flushed early by load_last).
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        last,
  output logic [1:0]  byte_idx,
  output logic        word_done,
  output logic [31:0] word
);

  logic [3:0][7:0] lane_q;
  logic [3:0][7:0] lane_out;

  assign word_done = accept & ((byte_idx == 2'd3) | last);

  // The word seen by the memory includes the byte being accepted this cycle;
  // lanes above it are forced to zero so a flushed partial word is clean.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    assign lane_out[k] = (LANE < byte_idx)  ? lane_q[k] :
                         (LANE == byte_idx) ? data      : 8'h00;
  end

  assign word = lane_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx <= 2'd0;
      lane_q   <= '0;
    end else if (accept) begin
      byte_idx <= word_done ? 2'd0 : byte_idx + 2'd1;
      for (int k = 0; k < 4; k++)
        if (byte_idx == 2'(k)) lane_q[k] <= data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory that is filled from a byte stream after reset, holds the
// core in reset while loading, then serves combinational instruction fetches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DEPTH = 64,
  parameter logic [31:0] NOP   = NOP_INSN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_valid,
  input  logic [7:0]                   load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         core_reset,
  input  logic [63:0]                  PC_to_INSTMEM,
  output logic [31:0]                  instruction,
  output logic                         fetch_fault,
  output logic [wc_width(DEPTH)-1:0]   word_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WCW = wc_width(DEPTH);

  state_t      state, state_nxt;
  logic        accept;
  logic [1:0]  byte_idx;
  logic        word_done;
  logic [31:0] word;
  logic [31:0] mem [DEPTH];
  logic [63:0] idx_ext;
  logic        hit;

  assign accept = load_valid & load_ready;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .data      (load_data),
    .last      (load_last),
    .byte_idx  (byte_idx),
    .word_done (word_done),
    .word      (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Filling the last slot ends the load even without load_last.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    core_reset = 1'b1;
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        if (word_done && (load_last || word_count == WCW'(DEPTH - 1)))
          state_nxt = RUN;
      end
      RUN: core_reset = 1'b0;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          word_count <= '0;
    else if (word_done) word_count <= word_count + WCW'(1);
  end

  // Contents are deliberately not reset; word_count gates visibility.
  always_ff @(posedge clk) begin
    if (word_done) mem[word_count[AW-1:0]] <= word;
  end

  // Compare the full index so high PC bits never alias back into the array.
  assign idx_ext     = {2'b00, PC_to_INSTMEM[63:2]};
  assign hit         = (PC_to_INSTMEM[1:0] == 2'b00) && (idx_ext < 64'(word_count));
  assign instruction = hit ? mem[PC_to_INSTMEM[AW+1:2]] : NOP;
  assign fetch_fault = ~hit;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level model packs expected words
// into a queue as bytes are driven; fetches pop and compare them.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        core_reset;
  logic [63:0] pc = 64'd0;
  logic [31:0] instruction;
  logic        fetch_fault;
  logic [6:0]  word_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] cur;
  int          lane;
  int          mcount;
  bit          mrun;

  imem_loader #(.DEPTH(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .core_reset    (core_reset),
    .PC_to_INSTMEM (pc),
    .instruction   (instruction),
    .fetch_fault   (fetch_fault),
    .word_count    (word_count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    exp_q.delete();
    cur = 32'h0; lane = 0; mcount = 0; mrun = 0;
  endtask

  // Drive one qualified byte for one edge; the model sees it only if loading.
  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1; load_data = b; load_last = last;
    @(posedge clk);
    if (!mrun) begin
      cur = cur | (32'(b) << (8 * lane));
      lane++;
      if (lane == 4 || last) begin
        exp_q.push_back(cur);
        cur = 32'h0; lane = 0; mcount++;
        if (last || mcount == 64) mrun = 1;
      end
    end
    #1;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    pc = 64'd0;
    #1;
    checks++;
    if (word_count !== 7'd0 || load_ready !== 1'b1 || core_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: wc=%0d ready=%b core_reset=%b want 0/1/1", word_count, load_ready, core_reset);
    end
    checks++;
    if (instruction !== 32'h13 || fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL reset_fetch: got %h/%b want 00000013/1", instruction, fetch_fault);
    end
  endtask

  task automatic test_program();
    logic [7:0] prog [8] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    logic [31:0] e;
    int n;
    do_reset();
    for (int i = 0; i < 8; i++) send(prog[i], i == 7);
    checks++;
    if (word_count !== 7'(mcount) || core_reset !== 1'b0 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL program_state: wc=%0d core_reset=%b ready=%b want %0d/0/0", word_count, core_reset, load_ready, mcount);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      pc = 64'(i) * 4; #1;
      checks++;
      if (instruction !== e || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL program_fetch[%0d]: got %h/%b want %h/0", i, instruction, fetch_fault, e);
      end
    end
    checks++;
    if (n != 2 || e !== 32'h00B0_0593) begin
      errors++;
      $display("FAIL program_model: words=%0d last=%h want 2/00b00593", n, e);
    end
    pc = 64'd8; #1;
    checks++;
    if (instruction !== 32'h13 || fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL program_pc8: got %h/%b want 00000013/1", instruction, fetch_fault);
    end
  endtask

  // Runs on the 2-word image left by test_program.
  task automatic test_faults();
    logic [63:0] pcs [3] = '{64'd2, 64'h1_0000_0000, 64'd256};
    for (int i = 0; i < 3; i++) begin
      pc = pcs[i]; #1;
      checks++;
      if (instruction !== 32'h13 || fetch_fault !== 1'b1) begin
        errors++;
        $display("FAIL fault_pc_%h: got %h/%b want 00000013/1", pcs[i], instruction, fetch_fault);
      end
    end
  endtask

  task automatic test_partial();
    logic [31:0] e;
    do_reset();
    send(8'h13, 0); send(8'h05, 0); send(8'hA0, 1);
    checks++;
    if (word_count !== 7'd1 || exp_q.size() != 1 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL partial_state: wc=%0d core_reset=%b want 1/0", word_count, core_reset);
    end
    e = exp_q.pop_front();
    pc = 64'd0; #1;
    checks++;
    if (instruction !== e || e !== 32'h00A0_0513 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL partial_fetch: got %h/%b want 00a00513/0", instruction, fetch_fault);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] prog [8] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
    logic [31:0] e;
    int n;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(1, 3)) begin
        load_last = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        load_last = 1'b0;
      end
      checks++;
      if (core_reset !== 1'b1 || word_count !== 7'(mcount)) begin
        errors++;
        $display("FAIL gap_hold[%0d]: core_reset=%b wc=%0d want 1/%0d", i, core_reset, word_count, mcount);
      end
      send(prog[i], i == 7);
    end
    checks++;
    if (word_count !== 7'd2 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL gap_state: wc=%0d core_reset=%b want 2/0", word_count, core_reset);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      pc = 64'(i) * 4; #1;
      checks++;
      if (instruction !== e || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL gap_fetch[%0d]: got %h/%b want %h/0", i, instruction, fetch_fault, e);
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] e;
    int n;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        checks++;
        if (load_ready !== 1'b1 || core_reset !== 1'b1) begin
          errors++;
          $display("FAIL full_before_last: ready=%b core_reset=%b want 1/1", load_ready, core_reset);
        end
      end
      send(8'($urandom), 0);
    end
    checks++;
    if (word_count !== 7'd64 || load_ready !== 1'b0 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL full_state: wc=%0d ready=%b core_reset=%b want 64/0/0", word_count, load_ready, core_reset);
    end
    send(8'h55, 1);
    checks++;
    if (word_count !== 7'd64 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL full_extra_byte: wc=%0d core_reset=%b want 64/0", word_count, core_reset);
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      pc = 64'(i) * 4; #1;
      checks++;
      if (instruction !== e || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL full_fetch[%0d]: got %h/%b want %h/0", i, instruction, fetch_fault, e);
      end
    end
    // reset from RUN must raise core_reset without waiting for a clock
    reset = 1'b1; #1;
    checks++;
    if (core_reset !== 1'b1 || load_ready !== 1'b1 || word_count !== 7'd0) begin
      errors++;
      $display("FAIL run_reset_async: core_reset=%b ready=%b wc=%0d want 1/1/0", core_reset, load_ready, word_count);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_midload_reset();
    logic [31:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 0);
    reset = 1'b1; #1;
    checks++;
    if (word_count !== 7'd0 || core_reset !== 1'b1 || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL midload_async: wc=%0d core_reset=%b ready=%b want 0/1/1", word_count, core_reset, load_ready);
    end
    #1 reset = 1'b0;
    model_clear();
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 1);
    checks++;
    if (word_count !== 7'd1 || core_reset !== 1'b0) begin
      errors++;
      $display("FAIL midload_state: wc=%0d core_reset=%b want 1/0", word_count, core_reset);
    end
    e = exp_q.pop_front();
    pc = 64'd0; #1;
    checks++;
    if (instruction !== e || e !== 32'hEFBE_ADDE || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL midload_fetch: got %h/%b want efbeadde/0", instruction, fetch_fault);
    end
  endtask

  initial begin
    model_clear();
    #12 reset = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_program();
    test_faults();
    test_partial();
    test_gaps();
    test_full();
    test_midload_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
